m32b_8b_fifo: RTL and testbench

//  Upstream neighbour of the 8-bit -> 32-bit converter: accepts 32-bit words, buffers them in a

---
 rtl/m32b_8b_fifo.sv | 115 +++++++++++
 tb/tb_m32b_8b_fifo.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/m32b_8b_fifo.sv
// 32-bit word FIFO feeding a byte serializer (MSB byte first, one byte per clk_4f).
// Optional even-parity output enabled by defining M32B_8B_PARITY_EN.
module m32b_8b_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk_4f,
  input  logic        reset_L,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        drop_err
`ifdef M32B_8B_PARITY_EN
  ,
  output logic        parity_out
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0] r_count;
  logic [31:0] r_shift, w_shift_nxt;
  logic [1:0]  r_idx, w_idx_nxt;
  logic [7:0]  w_data_nxt;
  logic        w_valid_nxt;
  logic        w_push, w_pop, w_empty;

  assign ready_out = (r_count != FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_push    = valid_in & ready_out;
  // In SEND, idx wraps to 0 once the last byte of the word is on data_out.
  assign w_pop     = !w_empty && ((r_state == IDLE) || (r_state == SEND && r_idx == 2'd0));

  // NOTE: the word storage has no reset; a slot is only read after it has been written.
  always_ff @(posedge clk_4f) begin
    if (w_push) r_mem[r_wr_ptr] <= data_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      drop_err <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (valid_in && !ready_out) drop_err <= 1'b1;
    end
  end

  // NOTE: every signal gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_idx;
    w_data_nxt  = data_out;
    w_valid_nxt = valid_out;
    if (w_pop) begin
      w_shift_nxt = {r_mem[r_rd_ptr][23:0], 8'h00};
      w_data_nxt  = r_mem[r_rd_ptr][31:24];
      w_valid_nxt = 1'b1;
      w_idx_nxt   = 2'd1;
      w_state_nxt = SEND;
    end else if (r_state == SEND) begin
      if (r_idx != 2'd0) begin
        w_data_nxt  = r_shift[31:24];
        w_shift_nxt = r_shift << 8;
        w_idx_nxt   = r_idx + 2'd1;
      end else begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
        w_data_nxt  = 8'h00;
      end
    end
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_idx     <= '0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_idx     <= w_idx_nxt;
      data_out  <= w_data_nxt;
      valid_out <= w_valid_nxt;
    end
  end

`ifdef M32B_8B_PARITY_EN
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) parity_out <= 1'b0;
    else          parity_out <= ^w_data_nxt;
  end
`endif

endmodule

// File: tb/tb_m32b_8b_fifo.sv
// Bench for m32b_8b_fifo: table vectors, directed corner cases and randomized traffic
// checked cycle by cycle against a queue-based model of the word/byte stream.
module tb_m32b_8b_fifo;

  localparam int DEPTH = 4;

  logic        clk_4f = 1'b0;
  logic        reset_L;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        drop_err;
`ifdef M32B_8B_PARITY_EN
  logic        parity_out;
`endif

  m32b_8b_fifo #(.DEPTH(DEPTH)) dut (
    .clk_4f    (clk_4f),
    .reset_L   (reset_L),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .drop_err  (drop_err)
`ifdef M32B_8B_PARITY_EN
    ,
    .parity_out(parity_out)
`endif
  );

  always #5 clk_4f = ~clk_4f;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: a word queue plus the bytes still owed for the word in flight.
  logic [31:0] m_q[$];
  logic [7:0]  m_rem[$];
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_drop;
  logic [7:0]  cap_q[$];

  task automatic model_reset();
    m_q.delete();
    m_rem.delete();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_drop  = 1'b0;
  endtask

  task automatic run_cycle(input logic vin, input logic [31:0] din, input string tag);
    logic        push_ok;
    logic [31:0] w;
    valid_in = vin;
    data_in  = din;
    check({tag, " ready"}, {31'd0, ready_out}, {31'd0, (m_q.size() < DEPTH)});
    push_ok = vin && (m_q.size() < DEPTH);
    if (vin && !push_ok) m_drop = 1'b1;
    @(posedge clk_4f);
    if (m_rem.size() > 0) begin
      m_data  = m_rem.pop_front();
      m_valid = 1'b1;
    end else if (m_q.size() > 0) begin
      w = m_q.pop_front();
      m_data  = w[31:24];
      m_rem.push_back(w[23:16]);
      m_rem.push_back(w[15:8]);
      m_rem.push_back(w[7:0]);
      m_valid = 1'b1;
    end else begin
      m_data  = 8'h00;
      m_valid = 1'b0;
    end
    if (push_ok) m_q.push_back(din);
    #1;
    check({tag, " valid"}, {31'd0, valid_out}, {31'd0, m_valid});
    check({tag, " data"},  {24'd0, data_out},  {24'd0, m_data});
    check({tag, " drop"},  {31'd0, drop_err},  {31'd0, m_drop});
`ifdef M32B_8B_PARITY_EN
    check({tag, " parity"}, {31'd0, parity_out}, {31'd0, m_valid & (^m_data)});
`endif
    if (valid_out) cap_q.push_back(data_out);
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    data_in  = '0;
    reset_L  = 1'b0;
    @(posedge clk_4f);
    #1;
    model_reset();
    reset_L = 1'b1;
  endtask

  typedef struct {
    logic        vin;
    logic [31:0] din;
    logic        e_valid;
    logic [7:0]  e_data;
    logic        e_ready;
    logic        e_drop;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int accepted;
    int guard;
    logic saw_full;
    logic [0:3] par_exp;

    // Single word, then two back-to-back words; expectations sampled just after each edge.
    vecs[0]  = '{1'b1, 32'hA1B2C3D4, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 32'h0,        1'b1, 8'hA1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 32'h0,        1'b1, 8'hB2, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 32'h0,        1'b1, 8'hC3, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 32'h0,        1'b1, 8'hD4, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 32'h0,        1'b0, 8'h00, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 32'h11223344, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 32'h55667788, 1'b1, 8'h11, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 32'h0,        1'b1, 8'h22, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 32'h0,        1'b1, 8'h33, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 32'h0,        1'b1, 8'h44, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 32'h0,        1'b1, 8'h55, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 32'h0,        1'b1, 8'h66, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 32'h0,        1'b1, 8'h77, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 32'h0,        1'b1, 8'h88, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 32'h0,        1'b0, 8'h00, 1'b1, 1'b0};

    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    model_reset();
    repeat (2) @(posedge clk_4f);
    #1;
    check("reset valid", {31'd0, valid_out}, 32'd0);
    check("reset data",  {24'd0, data_out},  32'd0);
    check("reset drop",  {31'd0, drop_err},  32'd0);
    check("reset ready", {31'd0, ready_out}, 32'd1);
    reset_L = 1'b1;

    for (int i = 0; i < 16; i++) begin
      valid_in = vecs[i].vin;
      data_in  = vecs[i].din;
      @(posedge clk_4f);
      #1;
      check($sformatf("vec%0d valid", i), {31'd0, valid_out}, {31'd0, vecs[i].e_valid});
      check($sformatf("vec%0d data", i),  {24'd0, data_out},  {24'd0, vecs[i].e_data});
      check($sformatf("vec%0d ready", i), {31'd0, ready_out}, {31'd0, vecs[i].e_ready});
      check($sformatf("vec%0d drop", i),  {31'd0, drop_err},  {31'd0, vecs[i].e_drop});
`ifdef M32B_8B_PARITY_EN
      check($sformatf("vec%0d parity", i), {31'd0, parity_out},
            {31'd0, vecs[i].e_valid & (^vecs[i].e_data)});
`endif
    end

    // Full/drop: eight distinct words offered back to back.
    do_reset();
    saw_full = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!ready_out) saw_full = 1'b1;
      run_cycle(1'b1, 32'hF0000000 + 32'(i) * 32'h01010101, $sformatf("t3 push%0d", i));
    end
    for (int i = 0; i < 24; i++) run_cycle(1'b0, '0, $sformatf("t3 drain%0d", i));
    check("t3 saw full", {31'd0, saw_full}, 32'd1);
    check("t3 drop sticky", {31'd0, drop_err}, 32'd1);

    // Asynchronous reset after byte1 of a word, with another word buffered behind it.
    run_cycle(1'b1, 32'hDEADBEEF, "t5 push");
    run_cycle(1'b1, 32'h12345678, "t5 byte0");
    run_cycle(1'b0, '0, "t5 byte1");
    #2;
    reset_L = 1'b0;
    #1;
    check("t5 async valid", {31'd0, valid_out}, 32'd0);
    check("t5 async data",  {24'd0, data_out},  32'd0);
    check("t5 async drop",  {31'd0, drop_err},  32'd0);
    check("t5 async ready", {31'd0, ready_out}, 32'd1);
    @(posedge clk_4f);
    #1;
    model_reset();
    reset_L = 1'b1;
    for (int i = 0; i < 8; i++) run_cycle(1'b0, '0, $sformatf("t5 idle%0d", i));

    // Pointer wrap: ten words with valid_in gated by ready_out.
    cap_q.delete();
    accepted = 0;
    guard    = 0;
    while (accepted < 10 && guard < 200) begin
      if (ready_out) begin
        run_cycle(1'b1, 32'(accepted), $sformatf("t4 push%0d", accepted));
        accepted++;
      end else begin
        run_cycle(1'b0, '0, "t4 wait");
      end
      guard++;
    end
    check("t4 accepted", 32'(accepted), 32'd10);
    for (int i = 0; i < 24; i++) run_cycle(1'b0, '0, $sformatf("t4 drain%0d", i));
    check("t4 bytes", 32'(cap_q.size()), 32'd40);
    for (int i = 0; i < 40 && i < cap_q.size(); i++) begin
      logic [31:0] wexp;
      wexp = 32'(i / 4);
      check($sformatf("t4 byte%0d", i), {24'd0, cap_q[i]}, {24'd0, wexp[31 - 8*(i%4) -: 8]});
    end
    check("t4 no drop", {31'd0, drop_err}, 32'd0);

`ifdef M32B_8B_PARITY_EN
    par_exp = 4'b1001;
    run_cycle(1'b1, 32'h0103FF80, "t6 push");
    for (int b = 0; b < 4; b++) begin
      run_cycle(1'b0, '0, $sformatf("t6 byte%0d", b));
      check($sformatf("t6 parity%0d", b), {31'd0, parity_out}, {31'd0, par_exp[b]});
    end
    run_cycle(1'b0, '0, "t6 idle");
`else
    par_exp = 4'b0000;
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      run_cycle(($urandom_range(0, 9) < 6), $urandom(), $sformatf("rnd%0d", i));
    end
    for (int i = 0; i < 24; i++) run_cycle(1'b0, '0, $sformatf("rnd drain%0d", i));
    check("rnd drained", {31'd0, valid_out}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
